ssd_display_ctrl: RTL and testbench
===================================

Name: ssd_display_ctrl

Overview:
- Sequencing controller for the 4-digit seven-segment display of the femtoRV32 board build.
- Accepts a 13-bit binary value over a valid/ready handshake.
- Converts it to four BCD digits with a multi-cycle shift-add-3 (double-dabble) engine, holds the result in a shadow register, and time-multiplexes the four anodes at a programmable scan rate.
- Replaces the combinational converter and free-running scan, and decouples display updates from CPU timing.

Parameters:
- SCAN_DIV, 262144: clk cycles each digit stays active. Legal range 2 to 2^24. Sim benches use 4.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- num_in  input  13  binary value to display, range 0–8191
- num_valid  input  1  num_in is valid this cycle
- num_ready  output  1  controller can accept a value (IDLE state)
- busy  output  1  conversion in progress (SHIFT or COMMIT state)
- Anode  output  4  digit enables, active low; [3]=thousands … [0]=ones
- LED_out  output  7  segments {a,b,c,d,e,f,g}, active low

Behaviour:
- Reset (async assert, sync deassert by design):
  - FSM goes to IDLE; num_ready=1; busy=0.
  - Shadow digits = 0,0,0,0.
  - Scan prescaler = 0; digit index = 0 (thousands).
  - Anode=4'b0111; LED_out=7'b0000001.
- FSM states:
  - IDLE → SHIFT when num_valid && num_ready at a rising edge. num_in is captured into a 13-bit shift register. Working BCD registers are cleared; bit counter = 12.
  - SHIFT, one input bit per cycle:
    - Each working BCD nibble ≥5 gets +3.
    - Then the 29-bit {BCD, shift} chain shifts left by 1, MSB of num_in first.
    - Exactly 13 cycles. On the cycle where bit counter = 0, go to COMMIT.
  - COMMIT: one cycle. Working BCD copies into the shadow digits; then go to IDLE.
- Latency: the shadow digits update on the 14th rising edge after the accepting edge. num_ready goes high again on that same edge.
- During SHIFT/COMMIT, num_ready=0 and num_valid is ignored. No queueing; the value is lost unless the producer holds it. The producer must keep num_in stable only on the accepting edge.
- Display always shows the last committed value. A conversion in flight never produces partial digits.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 and runs freely, independent of the FSM.
  - At wrap, digit index increments mod 4: 0=thousands, 1=hundreds, 2=tens, 3=ones.
  - Anode per index: 0111, 1011, 1101, 1110. Anode and LED_out are registered, so they change 1 cycle after the index changes.
  - Exactly one anode is low at any time outside reset.
- Segment decode (active low) for digits 0–9: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100. A nibble >9 is not reachable; it decodes as 0.
- Thousands digit never exceeds 8 (maximum input 8191).
- Reset mid-conversion aborts the conversion. Shadow digits return to 0000 and no commit occurs.

Optional Feature:
- Macro: SSD_LEAD_ZERO_BLANK_EN.
- When defined:
  - Leading-zero digits are blanked by forcing their anode high while their scan slot is active. Slot timing is unchanged.
  - A digit is a leading zero if it and all more-significant digits are 0.
  - The ones digit is never blanked, so value 0 shows a single "0".
- When undefined: all four digits are always driven, including leading zeros.

Test Plan:
- Reset (SCAN_DIV=4): assert rst asynchronously mid-cycle → outputs reach reset values immediately: Anode=0111, LED_out=0000001, num_ready=1, busy=0. Anode cycles 0111→1011→1101→1110 every 4 clks with LED_out=0000001 throughout.
- Convert 1234: pulse num_valid with num_in=1234.
  - busy=1 for exactly 14 cycles.
  - Shadow digits update on the 14th edge.
  - The slot sequence then shows LED_out 1001111, 0010010, 0000110, 1001100.
- Convert 8191 then 0 back-to-back: thousands/hundreds/tens/ones = 8,1,9,1, then 0,0,0,0. The second accept occurs only after num_ready returns to 1.
- Busy ignore: hold num_valid=1 with num_in=5555 during a conversion of 42 → display shows 0042 first. 5555 is accepted on the first cycle num_ready=1 and displays 14 edges later.
- Reset mid-conversion: start 7777, assert rst at SHIFT cycle 6 → digits 0000. After release, a new accept of 9 displays 0009.
- With SSD_LEAD_ZERO_BLANK_EN, value 7:
  - Thousands, hundreds and tens slots have Anode=1111.
  - Ones slot has Anode=1110 and LED_out=0001111.
  - Value 0 lights only the ones digit, showing 0000001.

Source files
------------

// File: rtl/ssd_display_ctrl.sv
// Four-digit seven-segment controller: handshaked binary input, multi-cycle double-dabble
// conversion into a shadow register, and a free-running anode scan. Option: SSD_LEAD_ZERO_BLANK_EN.
module ssd_display_ctrl #(
   parameter int unsigned SCAN_DIV = 262144
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [12:0] num_in,
   input  logic        num_valid,
   output logic        num_ready,
   output logic        busy,
   output logic [3:0]  Anode,
   output logic [6:0]  LED_out
);

   localparam int DATA_W = 13;
   localparam int PW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_COMMIT
   } state_t;

   state_t              state;
   logic [DATA_W-1:0]   shreg;
   logic [15:0]         bcd;
   logic [15:0]         bcd_adj;
   logic [3:0]          bitcnt;
   logic [15:0]         shadow;

   logic [PW-1:0]       presc;
   logic [1:0]          idx;
   logic [3:0]          cur_digit;
   logic                cur_blank;
   logic [3:0]          lead_zero;

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? (n + 4'd3) : n;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b0000001;
         4'd1:    s = 7'b1001111;
         4'd2:    s = 7'b0010010;
         4'd3:    s = 7'b0000110;
         4'd4:    s = 7'b1001100;
         4'd5:    s = 7'b0100100;
         4'd6:    s = 7'b0100000;
         4'd7:    s = 7'b0001111;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0000100;
         default: s = 7'b0000001;
      endcase
      return s;
   endfunction

   function automatic logic [3:0] anode_pat(input logic [1:0] i);
      logic [3:0] a;
      case (i)
         2'd0:    a = 4'b0111;
         2'd1:    a = 4'b1011;
         2'd2:    a = 4'b1101;
         default: a = 4'b1110;
      endcase
      return a;
   endfunction

   always_comb begin
      bcd_adj = {add3(bcd[15:12]), add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
   end

   // Conversion FSM: the shadow register changes only in COMMIT, so the display never sees partial digits
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         num_ready <= 1'b1;
         busy      <= 1'b0;
         shreg     <= '0;
         bcd       <= '0;
         bitcnt    <= '0;
         shadow    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (num_valid && num_ready) begin
                  shreg     <= num_in;
                  bcd       <= '0;
                  bitcnt    <= 4'd12;
                  state     <= S_SHIFT;
                  num_ready <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            S_SHIFT: begin
               bcd    <= {bcd_adj[14:0], shreg[DATA_W-1]};
               shreg  <= {shreg[DATA_W-2:0], 1'b0};
               bitcnt <= bitcnt - 4'd1;
               if (bitcnt == 4'd0) state <= S_COMMIT;
            end
            S_COMMIT: begin
               shadow    <= bcd;
               state     <= S_IDLE;
               num_ready <= 1'b1;
               busy      <= 1'b0;
            end
            default: begin
               state     <= S_IDLE;
               num_ready <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      case (idx)
         2'd0:    cur_digit = shadow[15:12];
         2'd1:    cur_digit = shadow[11:8];
         2'd2:    cur_digit = shadow[7:4];
         default: cur_digit = shadow[3:0];
      endcase
   end

   // lead_zero[k] is set when digit k and every more-significant digit are zero; ones is never blanked
   always_comb begin
      lead_zero    = 4'b0000;
      lead_zero[3] = (shadow[15:12] == 4'd0);
      lead_zero[2] = lead_zero[3] && (shadow[11:8] == 4'd0);
      lead_zero[1] = lead_zero[2] && (shadow[7:4] == 4'd0);
`ifdef SSD_LEAD_ZERO_BLANK_EN
      cur_blank    = lead_zero[3 - idx];
`else
      cur_blank    = 1'b0;
`endif
   end

   // Scan: prescaler free-runs; Anode/LED_out are registered one cycle behind the digit index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc   <= '0;
         idx     <= 2'd0;
         Anode   <= 4'b0111;
         LED_out <= 7'b0000001;
      end else begin
         if (presc == PRESC_MAX) begin
            presc <= '0;
            idx   <= idx + 2'd1;
         end else begin
            presc <= presc + PW'(1);
         end
         Anode   <= cur_blank ? 4'b1111 : anode_pat(idx);
         LED_out <= seg7(cur_digit);
      end
   end

endmodule

// File: tb/tb_ssd_display_ctrl.sv
// Scoreboard bench for ssd_display_ctrl with SCAN_DIV=4: expected digits are queued at each
// accept and checked against the scanned Anode/LED_out once the controller returns to idle.
module tb_ssd_display_ctrl;

   localparam int SD = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [12:0] num_in = '0;
   logic        num_valid = 1'b0;
   logic        num_ready;
   logic        busy;
   logic [3:0]  Anode;
   logic [6:0]  LED_out;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   logic [15:0] q[$];
   logic [15:0] shown = '0;
   logic [6:0]  seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

   ssd_display_ctrl #(.SCAN_DIV(SD)) dut (
      .clk(clk), .rst(rst), .num_in(num_in), .num_valid(num_valid),
      .num_ready(num_ready), .busy(busy), .Anode(Anode), .LED_out(LED_out)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic [3:0] exp_anode(input int s, input logic [15:0] d);
      logic [3:0] a;
      a = 4'b1111 ^ (4'b1000 >> s);
`ifdef SSD_LEAD_ZERO_BLANK_EN
      if (s == 0 && d[15:12] == 4'd0) a = 4'b1111;
      if (s == 1 && d[15:8]  == 8'd0) a = 4'b1111;
      if (s == 2 && d[15:4]  == 12'd0) a = 4'b1111;
`endif
      return a;
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic sample(input logic [15:0] d);
      int s;
      logic [3:0] dig;
      s   = (cyc == 0) ? 0 : ((cyc - 1) / SD) % 4;
      dig = 4'(d >> (4 * (3 - s)));
      check("anode", Anode, exp_anode(s, d));
      check("led_out", LED_out, seg_tab[dig]);
   endtask

   task automatic window(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sample(shown);
      end
   endtask

   task automatic accept(input int v, input bit hold, input int hold_v);
      int n;
      n = 0;
      while (num_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("ready_before_accept", num_ready, 1);
      num_in    = 13'(v);
      num_valid = 1'b1;
      @(negedge clk);
      if (hold) num_in = 13'(hold_v);
      else      num_valid = 1'b0;
      q.push_back(to_bcd(v));
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         sample(shown);
         check("ready_low_while_busy", num_ready, 0);
         n++;
         @(negedge clk);
      end
      check("busy_cycles", n, 14);
      check("ready_after_commit", num_ready, 1);
      if (q.size() > 0) shown = q.pop_front();
      else check("scoreboard_underflow", 16'(q.size()), 1);
   endtask

   initial begin
      // asynchronous reset mid-cycle
      #13 rst = 1'b1;
      #1;
      check("rst_anode", Anode, 4'b0111);
      check("rst_led", LED_out, 7'b0000001);
      check("rst_ready", num_ready, 1);
      check("rst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      shown = '0;
      window(16);

      accept(1234, 1'b0, 0);
      wait_done();
      window(16);

      accept(8191, 1'b0, 0);
      wait_done();
      accept(0, 1'b0, 0);
      wait_done();
      window(16);

      accept(42, 1'b1, 5555);
      wait_done();
      accept(5555, 1'b0, 0);
      wait_done();
      window(16);

      accept(7, 1'b0, 0);
      wait_done();
      window(16);

      // abort a conversion with reset partway through SHIFT
      accept(7777, 1'b0, 0);
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_anode", Anode, 4'b0111);
      check("abort_led", LED_out, 7'b0000001);
      check("abort_ready", num_ready, 1);
      check("abort_busy", busy, 0);
      void'(q.pop_back());
      shown = '0;
      @(negedge clk);
      rst = 1'b0;
      window(16);

      accept(9, 1'b0, 0);
      wait_done();
      window(16);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
